// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Iterative multiply/divide unit beside the register file. MULT/MULTU/DIV/DIVU
//   take DATA_W RUN cycles plus one FIX cycle and one DONE cycle; the 2*DATA_W
//   result lands in HI/LO. MTHI/MTLO write HI/LO directly while idle.
//
// Optional build macro: MULTDIV_ZERO_SKIP_EN
//   When defined, a multiply with a zero operand or a divide by zero skips RUN
//   and FIX: the result is written on the start edge and the unit goes straight
//   to DONE. When undefined, those cases take the full-length path.
//
// Ports
//   CLK     in   clock, rising edge
//   nRST    in   asynchronous active-low reset
//   start   in   request an operation (sampled only in IDLE)
//   op      in   2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU
//   rs_dat  in   operand A / dividend
//   rt_dat  in   operand B / divisor
//   wr_hi   in   MTHI write enable (IDLE only)
//   wr_lo   in   MTLO write enable (IDLE only)
//   wdat    in   MTHI/MTLO data
//   busy    out  high whenever not IDLE
//   done    out  one-cycle pulse, HI/LO hold the new result
//   hi, lo  out  HI/LO registers
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_dat,
  input  logic [DATA_W-1:0] rt_dat,
  input  logic              wr_hi,
  input  logic              wr_lo,
  input  logic [DATA_W-1:0] wdat,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                is_div_q, neg_res_q, neg_rem_q, div0_q;
  logic [DATA_W-1:0]   a_q, b_q, rs_q;
  logic [2*DATA_W-1:0] prod_q;
  logic [DATA_W-1:0]   quo_q, rem_q;
  logic [DATA_W-1:0]   hi_q, lo_q;

  // Operand decode at the start edge
  logic              is_signed, skip;
  logic [DATA_W-1:0] a_mag, b_mag;

  assign is_signed = ~op[0];
  assign a_mag = (is_signed && rs_dat[DATA_W-1]) ? -rs_dat : rs_dat;
  assign b_mag = (is_signed && rt_dat[DATA_W-1]) ? -rt_dat : rt_dat;

`ifdef MULTDIV_ZERO_SKIP_EN
  assign skip = start && (op[1] ? (rt_dat == '0) : (rs_dat == '0 || rt_dat == '0));
`else
  assign skip = 1'b0;
`endif

  // One shift-add step: multiplier bits are consumed from the low half of
  // prod_q while partial sums enter at the top.
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] prod_d;
  assign mul_sum = {1'b0, prod_q[2*DATA_W-1:DATA_W]}
                 + {1'b0, (prod_q[0] ? a_q : {DATA_W{1'b0}})};
  assign prod_d  = {mul_sum, prod_q[DATA_W-1:1]};

  // One restoring-division step. The shifted trial remainder needs DATA_W+1
  // bits; after the restore it is always below the divisor again.
  logic [DATA_W:0]   div_shift, div_diff;
  logic [DATA_W-1:0] rem_d, quo_d;
  assign div_shift = {rem_q, quo_q[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign rem_d     = div_diff[DATA_W] ? div_shift[DATA_W-1:0] : div_diff[DATA_W-1:0];
  assign quo_d     = {quo_q[DATA_W-2:0], ~div_diff[DATA_W]};

  // Sign correction applied in FIX
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix, res_hi, res_lo;
  assign prod_fix = neg_res_q ? -prod_q : prod_q;
  assign quo_fix  = neg_res_q ? -quo_q  : quo_q;
  assign rem_fix  = neg_rem_q ? -rem_q  : rem_q;

  always_comb begin
    res_hi = prod_fix[2*DATA_W-1:DATA_W];
    res_lo = prod_fix[DATA_W-1:0];
    if (is_div_q) begin
      if (div0_q) begin
        res_hi = rs_q;
        res_lo = '1;
      end else begin
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = skip ? S_DONE : S_RUN;
      S_RUN:  if (cnt_q == CNT_LAST) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rs_q      <= '0;
      prod_q    <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wr_hi) hi_q <= wdat;
          if (wr_lo) lo_q <= wdat;
          if (start) begin
            cnt_q     <= '0;
            is_div_q  <= op[1];
            neg_res_q <= is_signed && (rs_dat[DATA_W-1] ^ rt_dat[DATA_W-1]);
            neg_rem_q <= is_signed && rs_dat[DATA_W-1];
            div0_q    <= (rt_dat == '0);
            a_q       <= a_mag;
            b_q       <= b_mag;
            rs_q      <= rs_dat;
            prod_q    <= {{DATA_W{1'b0}}, b_mag};
            quo_q     <= a_mag;
            rem_q     <= '0;
            // Short-circuit results overwrite any simultaneous MTHI/MTLO
            if (skip) begin
              hi_q <= op[1] ? rs_dat : '0;
              lo_q <= op[1] ? '1 : '0;
            end
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (is_div_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
          end else begin
            prod_q <= prod_d;
          end
        end
        S_FIX: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
        default: ;
      endcase
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  rs_dat = '0, rt_dat = '0, wdat = '0;
  logic          wr_hi = 1'b0, wr_lo = 1'b0;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  mult_div_unit #(.DATA_W(W)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .op(op),
    .rs_dat(rs_dat), .rt_dat(rt_dat), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .wdat(wdat), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    int          lat;
    int          s;
  } exp_t;

  exp_t sbq[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: plain signed/unsigned arithmetic, returns {hi, lo}
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, m;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: r = sa * sb;
      2'b01: r = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bit sk;
    sk = 1'b0;
`ifdef MULTDIV_ZERO_SKIP_EN
    sk = o[1] ? (b == 0) : (a == 0 || b == 0);
`endif
    return sk ? 1 : W + 2;
  endfunction

  // Monitor: pops an expectation for every done pulse
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (nRST && done) begin
        if (sbq.size() == 0) begin
          check("spurious_done", {31'b0, done}, 32'd0);
        end else begin
          e = sbq.pop_front();
          $display("op=%0d rs=%h rt=%h hi=%h lo=%h cycles=%0d",
                   e.op, e.a, e.b, hi, lo, cyc - e.s + 1);
          check("result_hi", hi, e.hi);
          check("result_lo", lo, e.lo);
          check("latency", 32'(cyc - e.s + 1), 32'(e.lat));
        end
      end
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] wr, input bit push);
    exp_t e;
    @(negedge CLK);
    start = 1'b1; op = o; rs_dat = a; rt_dat = b;
    wr_hi = wr[1]; wr_lo = wr[0]; wdat = $urandom;
    @(posedge CLK);
    #1;
    if (push) begin
      e.op = o; e.a = a; e.b = b;
      {e.hi, e.lo} = ref_model(o, a, b);
      e.lat = ref_lat(o, a, b);
      e.s = cyc;
      sbq.push_back(e);
    end
    check("busy_after_start", {31'b0, busy}, 32'd1);
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(negedge CLK);
      t++;
    end
    if (sbq.size() != 0) begin
      check("done_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
    @(negedge CLK);
    check("busy_idle", {31'b0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] prev_lo, prev_hi;

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    nRST = 1'b1;

    // Directed operations
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b1); wait_done();
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 2'b00, 1'b1);         wait_done();
    issue(2'b01, 32'hFFFF_FFFD, 32'd7, 2'b00, 1'b1);         wait_done();
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 2'b00, 1'b1);         wait_done();
    issue(2'b11, 32'd7, 32'd2, 2'b00, 1'b1);                 wait_done();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 1'b1); wait_done();
    issue(2'b11, 32'd5, 32'd0, 2'b00, 1'b1);                 wait_done();
    issue(2'b10, 32'hFFFF_FFF0, 32'd0, 2'b00, 1'b1);         wait_done();
    issue(2'b00, 32'd0, 32'd9, 2'b00, 1'b1);                 wait_done();

    // MTHI / MTLO in idle
    prev_lo = lo;
    @(negedge CLK);
    wr_hi = 1'b1; wdat = 32'h1234_5678;
    @(posedge CLK); #1;
    wr_hi = 1'b0;
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_lo_hold", lo, prev_lo);
    @(negedge CLK);
    wr_hi = 1'b1; wr_lo = 1'b1; wdat = 32'hCAFE_F00D;
    @(posedge CLK); #1;
    wr_hi = 1'b0; wr_lo = 1'b0;
    check("mt_both_hi", hi, 32'hCAFE_F00D);
    check("mt_both_lo", lo, 32'hCAFE_F00D);

    // Disturbance during RUN is ignored
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 2'b00, 1'b1);
    repeat (5) @(negedge CLK);
    prev_hi = hi; prev_lo = lo;
    start = 1'b1; op = 2'b11; wr_lo = 1'b1; wr_hi = 1'b1; wdat = 32'hAAAA_5555;
    rs_dat = 32'd1; rt_dat = 32'd1;
    @(negedge CLK);
    start = 1'b0; wr_lo = 1'b0; wr_hi = 1'b0;
    check("run_hold_lo", lo, prev_lo);
    check("run_hold_hi", hi, prev_hi);
    wait_done();

    // Reset mid-operation
    issue(2'b01, 32'd3, 32'd4, 2'b00, 1'b0);
    repeat (9) @(negedge CLK);
    nRST = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    repeat (40) @(negedge CLK);
    check("post_abort_busy", {31'b0, busy}, 32'd0);
    check("post_abort_lo", lo, 32'd0);
    issue(2'b11, 32'd9, 32'd3, 2'b00, 1'b1); wait_done();

    // Randomized operations, occasionally with MTHI/MTLO on the start edge
    for (int i = 0; i < 40; i++) begin
      logic [1:0] o, wr;
      logic [31:0] a, b;
      o  = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      wr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      issue(o, a, b, wr, 1'b1);
      wait_done();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
